stopwatch_ctrl: RTL

Run/pause/lap/clear controller for the stopwatch's chain of BCD digit mod-counters.
- Owns the tick prescaler and drives the chain's increment and synchronous clear inputs.
- Takes the live digit vector back from the chain and supplies the display mux with live or lap-frozen digits.
- Sits between the debounced one-shot button pulses and the digit counter chain / seven-segment driver.

---
 rtl/stopwatch_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for a chain of BCD digit counters, with tick prescaler and display mux.
// Build option: STOPWATCH_OVERFLOW_HALT_EN halts in OVERFLOW at all-9s instead of wrapping to zero.
//
// state    | meaning
// IDLE     | counters held at zero, prescaler cleared
// RUNNING  | prescaler counting, count_inc once per DIV cycles
// PAUSED   | prescaler and counters hold, lap still usable
// OVERFLOW | (halt build only) display pinned at all-9s until clear
module stopwatch_ctrl #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TICK_HZ     = 100,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_stop,
    input  logic                    lap,
    input  logic                    clear,
    input  logic [4*NUM_DIGITS-1:0] live_digits,
    output logic                    count_inc,
    output logic                    count_clear,
    output logic [4*NUM_DIGITS-1:0] display_digits,
    output logic                    running,
    output logic                    lap_active,
    output logic                    overflow
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0]           PRESC_LAST = PW'(DIV - 1);
    localparam logic [4*NUM_DIGITS-1:0] ALL_NINES  = {NUM_DIGITS{4'h9}};

`ifdef STOPWATCH_OVERFLOW_HALT_EN
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, OVERFLOW} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;
`endif

    state_t                  state, state_next;
    logic [PW-1:0]           presc;
    logic [4*NUM_DIGITS-1:0] lap_reg;
    logic                    all_nines;
    logic                    presc_last;
    logic                    lap_take;

    // Every nibble equal to 9 is the same as the whole vector matching 0x99..9.
    assign all_nines  = (live_digits == ALL_NINES);
    assign presc_last = (presc == PRESC_LAST);

`ifdef STOPWATCH_OVERFLOW_HALT_EN
    logic halt;
    assign halt      = (state == RUNNING) && presc_last && all_nines;
    assign count_inc = (state == RUNNING) && presc_last && !all_nines;
`else
    assign count_inc = (state == RUNNING) && presc_last;
`endif

    assign count_clear = (state == IDLE);
    assign running     = (state == RUNNING);
    assign lap_take    = lap && !clear && !start_stop &&
                         ((state == RUNNING) || (state == PAUSED));

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
`ifdef STOPWATCH_OVERFLOW_HALT_EN
        end else if (halt) begin
            // Halting beats a same-cycle pause so the final tick is never lost silently.
            state_next = OVERFLOW;
`endif
        end else if (start_stop) begin
            case (state)
                IDLE:    state_next = RUNNING;
                RUNNING: state_next = PAUSED;
                PAUSED:  state_next = RUNNING;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Prescaler advances only while RUNNING; PAUSED keeps the partial period for resume.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else begin
            case (state)
                IDLE:    presc <= '0;
                RUNNING: presc <= presc_last ? '0 : presc + PW'(1);
                default: presc <= presc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_reg    <= '0;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (lap_take) begin
                if (!lap_active) begin
                    lap_reg    <= live_digits;
                    lap_active <= 1'b1;
                end else begin
                    lap_active <= 1'b0;
                end
            end
`ifdef STOPWATCH_OVERFLOW_HALT_EN
            if (halt) begin
                overflow <= 1'b1;
            end
`else
            if (count_inc && all_nines) begin
                overflow <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        display_digits = lap_active ? lap_reg : live_digits;
`ifdef STOPWATCH_OVERFLOW_HALT_EN
        if (state == OVERFLOW) begin
            display_digits = ALL_NINES;
        end
`endif
    end

endmodule
